// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// ------------
// Shares the single load/store port of the data memory between the core
// load/store unit (port 0) and the DMA/debug loader (port 1). Port 0 has
// fixed priority, and a starvation counter hands port 1 the memory after
// MAX_BURST consecutive port-0 grants that it had to watch.
// Every access passes through GRANT -> ACCESS -> RESP. A new grant may
// overlap RESP, so one access completes every two cycles.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   pN_req/we/size/addr/wdata   request and payload from port N (N = 0,1),
//                          held until pN_gnt
//   pN_gnt                 combinational accept pulse
//   pN_rvalid/rdata/err    registered completion, one cycle
//   mem_memwrite/addr/load_type/store_type/wdata   memory-side controls,
//                          all taken from the capture registers
//   mem_rdata_word         combinational read data from the memory
module dmem_arbiter #(
    parameter int MEM_WORDS = 1024,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        mem_memwrite,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_load_type,
    output logic [1:0]  mem_store_type,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata_word
);

    localparam logic [3:0]  MAX_BURST_C = 4'(MAX_BURST);
    localparam logic [29:0] MEM_WORDS_C = 30'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Alignment, size legality and range check of one request.
    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic bad_v;
        case (size)
            2'b00:   bad_v = (addr[1:0] != 2'b00);
            2'b01:   bad_v = addr[0];
            2'b10:   bad_v = 1'b0;
            default: bad_v = 1'b1;
        endcase
        return bad_v | (addr[31:2] >= MEM_WORDS_C);
    endfunction

    state_t      state_r;
    logic [3:0]  starve_cnt_r;
    logic        cap_port_r;
    logic        cap_we_r;
    logic        cap_err_r;
    logic [1:0]  cap_size_r;
    logic [31:0] cap_addr_r;
    logic [31:0] cap_wdata_r;

    logic        may_grant_s;
    logic        p1_turn_s;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        any_gnt_s;
    logic        in_access_s;
    logic        sel_we_s;
    logic [1:0]  sel_size_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [31:0] rsp_data_s;

    // Arbitration and payload selection for the grant cycle.
    always_comb begin
        // Nothing is accepted while reset is asserted: the grant would be lost.
        may_grant_s = resetn & ((state_r == ST_IDLE) | (state_r == ST_RESP));
        p1_turn_s   = (starve_cnt_r == MAX_BURST_C);
        gnt0_s      = may_grant_s & p0_req & ~(p1_req & p1_turn_s);
        gnt1_s      = may_grant_s & p1_req & (~p0_req | p1_turn_s);
        any_gnt_s   = gnt0_s | gnt1_s;
        if (gnt1_s) begin
            sel_we_s    = p1_we;
            sel_size_s  = p1_size;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_size_s  = p0_size;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Response data: only a good load returns memory contents.
    always_comb begin
        in_access_s = (state_r == ST_ACCESS);
        if (cap_we_r | cap_err_r) begin
            rsp_data_s = 32'h0000_0000;
        end else begin
            rsp_data_s = mem_rdata_word;
        end
    end

    assign p0_gnt         = gnt0_s;
    assign p1_gnt         = gnt1_s;
    assign mem_addr       = cap_addr_r;
    assign mem_load_type  = cap_size_r;
    assign mem_store_type = cap_size_r;
    assign mem_wdata      = cap_wdata_r;
    // resetn in the term keeps a store from committing on the reset edge.
    assign mem_memwrite   = in_access_s & cap_we_r & ~cap_err_r & resetn;

    // Access sequencer: IDLE/RESP grant into ACCESS, ACCESS always to RESP.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (any_gnt_s) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: state_r <= ST_RESP;
                default:   state_r <= ST_IDLE;
            endcase
        end
    end

    // Capture of the winning request, held until the next grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cap_port_r  <= 1'b0;
            cap_we_r    <= 1'b0;
            cap_err_r   <= 1'b0;
            cap_size_r  <= 2'b00;
            cap_addr_r  <= 32'h0000_0000;
            cap_wdata_r <= 32'h0000_0000;
        end else if (any_gnt_s) begin
            cap_port_r  <= gnt1_s;
            cap_we_r    <= sel_we_s;
            cap_err_r   <= access_err(sel_size_s, sel_addr_s);
            cap_size_r  <= sel_size_s;
            cap_addr_r  <= sel_addr_s;
            cap_wdata_r <= sel_wdata_s;
        end else begin
            cap_port_r  <= cap_port_r;
            cap_we_r    <= cap_we_r;
            cap_err_r   <= cap_err_r;
            cap_size_r  <= cap_size_r;
            cap_addr_r  <= cap_addr_r;
            cap_wdata_r <= cap_wdata_r;
        end
    end

    // Starvation counter: counts port-0 grants that port 1 had to watch.
    // It cannot pass MAX_BURST because port 1 wins once it gets there.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt_r <= 4'd0;
        end else if (gnt1_s) begin
            starve_cnt_r <= 4'd0;
        end else if (gnt0_s) begin
            starve_cnt_r <= p1_req ? (starve_cnt_r + 4'd1) : 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Registered completion, driven to the captured port during RESP.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= 32'h0000_0000;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= 32'h0000_0000;
        end else begin
            p0_rvalid <= in_access_s & ~cap_port_r;
            p0_err    <= in_access_s & ~cap_port_r & cap_err_r;
            p0_rdata  <= (in_access_s & ~cap_port_r) ? rsp_data_s : 32'h0000_0000;
            p1_rvalid <= in_access_s & cap_port_r;
            p1_err    <= in_access_s & cap_port_r & cap_err_r;
            p1_rdata  <= (in_access_s & cap_port_r) ? rsp_data_s : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a little-endian data memory sits behind the
// DUT, two requester drivers feed queued or random transactions, and a
// transaction-level model predicts grants, memory writes and completions
// every cycle. Directed literal checks pin the model on known cases.
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 1024;
    localparam int MAX_BURST = 4;
    localparam int MEM_BYTES = 4 * MEM_WORDS;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic resetn;
    logic p0_req, p0_we, p1_req, p1_we;
    logic [1:0]  p0_size, p1_size;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic mem_memwrite;
    logic [31:0] mem_addr, mem_wdata, mem_rdata_word;
    logic [1:0]  mem_load_type, mem_store_type;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .resetn(resetn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_memwrite(mem_memwrite), .mem_addr(mem_addr), .mem_load_type(mem_load_type),
        .mem_store_type(mem_store_type), .mem_wdata(mem_wdata), .mem_rdata_word(mem_rdata_word)
    );

    // ---------------- device memory (word array, byte lanes) ----------------
    logic [31:0] dev_mem [0:MEM_WORDS-1] = '{default: 32'h0};
    logic [31:0] dev_word;

    always_comb begin
        dev_word = (mem_addr < 32'(MEM_BYTES)) ? dev_mem[mem_addr[11:2]] : 32'h0;
        case (mem_load_type)
            2'b00:   mem_rdata_word = dev_word;
            2'b01:   mem_rdata_word = mem_addr[1] ? {16'h0, dev_word[31:16]} : {16'h0, dev_word[15:0]};
            2'b10:   mem_rdata_word = {24'h0, dev_word[8*mem_addr[1:0] +: 8]};
            default: mem_rdata_word = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_memwrite && mem_addr < 32'(MEM_BYTES)) begin
            case (mem_store_type)
                2'b00: dev_mem[mem_addr[11:2]] <= mem_wdata;
                2'b01: dev_mem[mem_addr[11:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                2'b10: dev_mem[mem_addr[11:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    // ---------------- bench state ----------------
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    logic rand_en = 1'b0;
    logic gnt_seen0 = 1'b0, gnt_seen1 = 1'b0;
    txn_t q0[$], q1[$];

    // reference model state
    logic [7:0]  shadow [0:MEM_BYTES-1] = '{default: 8'h0};
    logic        acc_valid = 1'b0, acc_port = 1'b0, acc_we = 1'b0, acc_err = 1'b0;
    logic [1:0]  acc_size = 2'b00;
    logic [31:0] acc_addr = 32'h0, acc_wdata = 32'h0;
    logic        rsp_valid = 1'b0, rsp_port = 1'b0, rsp_err = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    int          passed_over = 0;   // p0 grants p1 has watched since last served

    // observations for the directed checks
    int rsp_cnt0 = 0, rsp_cnt1 = 0, memwrite_cnt = 0;
    int last_gnt_cyc0 = 0, last_rsp_cyc0 = 0;
    logic        last_err0 = 1'b0, last_err1 = 1'b0;
    logic [31:0] last_data0 = 32'h0, last_data1 = 32'h0;
    int glog_port[$], glog_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic spec_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) ||
               (sz == 2'b01 && a[0]) || (a >= 32'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] shadow_load(input logic [31:0] a, input logic [1:0] sz);
        int b;
        b = int'(a[11:0]);
        case (sz)
            2'b00:   return {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
            2'b01:   return {16'h0, shadow[b+1], shadow[b]};
            default: return {24'h0, shadow[b]};
        endcase
    endfunction

    task automatic shadow_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int b, n;
        b = int'(a[11:0]);
        n = (sz == 2'b00) ? 4 : ((sz == 2'b01) ? 2 : 1);
        for (int i = 0; i < n; i++) shadow[b+i] = d[8*i +: 8];
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int   pick;
        t.we   = 1'($urandom_range(0, 1));
        t.size = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        pick   = $urandom_range(0, 7);
        if (pick == 0) begin
            case ($urandom_range(0, 3))
                0:       t.addr = 32'h0000_0FFC;
                1:       t.addr = 32'h0000_0FFE;
                2:       t.addr = 32'h0000_1000;
                default: t.addr = 32'hFFFF_FFFC;
            endcase
        end else begin
            t.addr = 32'($urandom_range(0, 255));
            if (pick > 2 && t.size == 2'b00) t.addr[1:0] = 2'b00;
            if (pick > 2 && t.size == 2'b01) t.addr[0] = 1'b0;
        end
        t.wdata = $urandom;
        return t;
    endfunction

    // ---------------- compare process: model vs DUT each cycle ----------------
    task automatic monitor_loop();
        logic exp_g0, exp_g1, exp_rv0, exp_rv1, exp_wr;
        forever begin
            @(negedge clk);
            cyc++;
            gnt_seen0 = p0_gnt;
            gnt_seen1 = p1_gnt;
            if (mon_en) begin
                exp_g0 = 1'b0;
                exp_g1 = 1'b0;
                if (resetn && !acc_valid) begin
                    if (p0_req && p1_req) begin
                        exp_g1 = (passed_over >= MAX_BURST);
                        exp_g0 = !exp_g1;
                    end else begin
                        exp_g0 = p0_req;
                        exp_g1 = p1_req;
                    end
                end
                exp_wr  = acc_valid && acc_we && !acc_err && resetn;
                exp_rv0 = rsp_valid && !rsp_port;
                exp_rv1 = rsp_valid && rsp_port;
                chk("p0_gnt", 32'(p0_gnt), 32'(exp_g0));
                chk("p1_gnt", 32'(p1_gnt), 32'(exp_g1));
                chk("mem_memwrite", 32'(mem_memwrite), 32'(exp_wr));
                if (acc_valid) begin
                    chk("mem_addr", mem_addr, acc_addr);
                    chk("mem_load_type", 32'(mem_load_type), 32'(acc_size));
                    chk("mem_store_type", 32'(mem_store_type), 32'(acc_size));
                    if (acc_we) chk("mem_wdata", mem_wdata, acc_wdata);
                end
                chk("p0_rvalid", 32'(p0_rvalid), 32'(exp_rv0));
                chk("p0_err", 32'(p0_err), 32'(exp_rv0 && rsp_err));
                chk("p0_rdata", p0_rdata, exp_rv0 ? rsp_data : 32'h0);
                chk("p1_rvalid", 32'(p1_rvalid), 32'(exp_rv1));
                chk("p1_err", 32'(p1_err), 32'(exp_rv1 && rsp_err));
                chk("p1_rdata", p1_rdata, exp_rv1 ? rsp_data : 32'h0);

                if (p0_rvalid) begin rsp_cnt0++; last_err0 = p0_err; last_data0 = p0_rdata; last_rsp_cyc0 = cyc; end
                if (p1_rvalid) begin rsp_cnt1++; last_err1 = p1_err; last_data1 = p1_rdata; end
                if (p0_gnt) last_gnt_cyc0 = cyc;
                if (mem_memwrite) memwrite_cnt++;
                if (p0_gnt || p1_gnt) begin glog_port.push_back(p1_gnt ? 1 : 0); glog_cyc.push_back(cyc); end

                if (!resetn) begin
                    acc_valid = 1'b0; rsp_valid = 1'b0; passed_over = 0;
                end else begin
                    rsp_valid = acc_valid;
                    if (acc_valid) begin
                        rsp_port = acc_port;
                        rsp_err  = acc_err;
                        rsp_data = (acc_we || acc_err) ? 32'h0 : shadow_load(acc_addr, acc_size);
                        if (acc_we && !acc_err) shadow_store(acc_addr, acc_size, acc_wdata);
                    end
                    acc_valid = exp_g0 || exp_g1;
                    if (exp_g1) begin
                        acc_port = 1'b1; acc_we = p1_we; acc_size = p1_size;
                        acc_addr = p1_addr; acc_wdata = p1_wdata;
                        acc_err = spec_err(p1_size, p1_addr);
                        passed_over = 0;
                    end else if (exp_g0) begin
                        acc_port = 1'b0; acc_we = p0_we; acc_size = p0_size;
                        acc_addr = p0_addr; acc_wdata = p0_wdata;
                        acc_err = spec_err(p0_size, p0_addr);
                        passed_over = p1_req ? passed_over + 1 : 0;
                    end
                end
            end
        end
    endtask

    // ---------------- requester drivers ----------------
    task automatic drive_port(input int p);
        txn_t t;
        logic have;
        if (p == 0 ? (!p0_req || gnt_seen0) : (!p1_req || gnt_seen1)) begin
            have = 1'b0;
            t = '0;
            if (p == 0 && q0.size() > 0) begin t = q0.pop_front(); have = 1'b1; end
            else if (p == 1 && q1.size() > 0) begin t = q1.pop_front(); have = 1'b1; end
            else if (rand_en && $urandom_range(0, 2) == 0) begin t = rand_txn(); have = 1'b1; end
            if (p == 0) begin
                p0_req = have;
                if (have) begin p0_we = t.we; p0_size = t.size; p0_addr = t.addr; p0_wdata = t.wdata; end
            end else begin
                p1_req = have;
                if (have) begin p1_we = t.we; p1_size = t.size; p1_addr = t.addr; p1_wdata = t.wdata; end
            end
        end
    endtask

    task automatic driver_loop();
        forever begin
            @(posedge clk);
            #1;
            drive_port(0);
            drive_port(1);
        end
    endtask

    // Queue one transaction and wait (bounded) for its completion.
    task automatic do_txn(input int p, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        int   start, n;
        t.we = we; t.size = sz; t.addr = a; t.wdata = d;
        start = (p == 0) ? rsp_cnt0 : rsp_cnt1;
        if (p == 0) q0.push_back(t); else q1.push_back(t);
        n = 0;
        while (((p == 0) ? rsp_cnt0 : rsp_cnt1) == start && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 30) begin
            n_checks++; n_errors++;
            $display("FAIL timeout port%0d: got no rvalid, expected one within 30 cycles", p);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'h0, p0_gnt, p1_gnt}, 32'h0);
        chk({tag, "_rvalid_err"}, {28'h0, p0_rvalid, p0_err, p1_rvalid, p1_err}, 32'h0);
        chk({tag, "_p0_rdata"}, p0_rdata, 32'h0);
        chk({tag, "_p1_rdata"}, p1_rdata, 32'h0);
        chk({tag, "_mem_ctl"}, {27'h0, mem_memwrite, mem_load_type, mem_store_type}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp_seq [10];
        int base, wc, saved, n;
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        resetn = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_size = 2'b00; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'b00; p1_addr = 32'h0; p1_wdata = 32'h0;
        fork
            monitor_loop();
            driver_loop();
            begin
                #1_000_000;
                $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("reset");

        // Store then load a word; latency gnt N, write N+1, rvalid N+2.
        wc = memwrite_cnt;
        do_txn(0, 1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF);
        chk("st_latency", 32'(last_rsp_cyc0 - last_gnt_cyc0), 32'd2);
        chk("st_writes", 32'(memwrite_cnt - wc), 32'd1);
        chk("st_err", 32'(last_err0), 32'd0);
        do_txn(0, 1'b0, 2'b00, 32'h10, 32'h0);
        chk("ld_word", last_data0, 32'hDEAD_BEEF);
        chk("ld_latency", 32'(last_rsp_cyc0 - last_gnt_cyc0), 32'd2);

        // Byte store then half load from port 1 (little-endian: 0x12=AD, 0x13=A5).
        do_txn(1, 1'b1, 2'b10, 32'h13, 32'h0000_00A5);
        do_txn(1, 1'b0, 2'b01, 32'h12, 32'h0);
        chk("ld_half", last_data1, 32'h0000_A5AD);

        // Error accesses: err=1, rdata=0, no memory write.
        wc = memwrite_cnt;
        do_txn(0, 1'b0, 2'b01, 32'h11, 32'h0);
        chk("err_half_mis", {31'h0, last_err0}, 32'd1);
        chk("err_half_mis_data", last_data0, 32'h0);
        do_txn(1, 1'b1, 2'b00, 32'h02, 32'h1234_5678);
        chk("err_word_mis", {31'h0, last_err1}, 32'd1);
        do_txn(1, 1'b0, 2'b11, 32'h20, 32'h0);
        chk("err_size11", {31'h0, last_err1}, 32'd1);
        chk("err_size11_data", last_data1, 32'h0);
        do_txn(0, 1'b1, 2'b00, 32'h1000, 32'hFFFF_FFFF);
        chk("err_range", {31'h0, last_err0}, 32'd1);
        chk("err_no_write", 32'(memwrite_cnt - wc), 32'd0);

        // Contention: both ports request continuously.
        glog_port.delete();
        glog_cyc.delete();
        base = rsp_cnt0 + rsp_cnt1;
        for (int i = 0; i < 10; i++) q0.push_back('{1'b0, 2'b00, 32'(4 * i), 32'h0});
        for (int i = 0; i < 2; i++) q1.push_back('{1'b0, 2'b00, 32'(64 + 4 * i), 32'h0});
        n = 0;
        while (rsp_cnt0 + rsp_cnt1 < base + 12 && n < 100) begin @(negedge clk); #1; n++; end
        chk("burst_done", 32'(rsp_cnt0 + rsp_cnt1 - base), 32'd12);
        if (glog_port.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("burst_grant%0d", i), 32'(glog_port[i]), 32'(exp_seq[i]));
                if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd2);
            end
        end else begin
            n_checks++; n_errors++;
            $display("FAIL burst_len: got %0d grants, expected at least 10", glog_port.size());
        end

        // Reset during the ACCESS cycle of a store to 0x20.
        saved = rsp_cnt0;
        wc = memwrite_cnt;
        q0.push_back('{1'b1, 2'b00, 32'h20, 32'hCAFE_F00D});
        n = 0;
        while (!gnt_seen0 && n < 30) begin @(negedge clk); #1; n++; end
        chk("rst_saw_gnt", {31'h0, gnt_seen0}, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("post_reset");
        repeat (4) @(negedge clk);
        #1;
        chk("rst_no_rvalid", 32'(rsp_cnt0), 32'(saved));
        chk("rst_no_write", 32'(memwrite_cnt - wc), 32'd0);
        do_txn(0, 1'b0, 2'b00, 32'h20, 32'h0);
        chk("rst_ld_zero", last_data0, 32'h0);

        // Random traffic with occasional resets.
        rand_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(300, 500)) @(posedge clk);
            #1;
            resetn = 1'b0;
            @(posedge clk);
            #1;
            resetn = 1'b1;
        end
        repeat (300) @(posedge clk);
        rand_en = 1'b0;
        repeat (40) @(posedge clk);
        chk("drained_p0", {31'h0, p0_req}, 32'd0);
        chk("drained_p1", {31'h0, p1_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
